// File: rtl/key_event_encoder_pkg.sv
// Shared event format for the key event path: {key, press, ts} packed MSB to LSB.
package key_event_encoder_pkg;

    localparam int unsigned N_KEYS_DEF     = 4;
    localparam int unsigned KEY_W_DEF      = 2;
    localparam int unsigned TS_W_DEF       = 16;
    localparam int unsigned FIFO_DEPTH_DEF = 8;

    localparam int unsigned EV_W         = KEY_W_DEF + 1 + TS_W_DEF;
    localparam int unsigned EV_TS_LSB    = 0;
    localparam int unsigned EV_PRESS_BIT = TS_W_DEF;
    localparam int unsigned EV_KEY_LSB   = TS_W_DEF + 1;

    typedef struct packed {
        logic [KEY_W_DEF-1:0] key;
        logic                 press;
        logic [TS_W_DEF-1:0]  ts;
    } key_event_t;

endpackage

// File: rtl/key_event_fifo.sv
// Synchronous first-word fall-through FIFO; pointers carry an extra MSB to tell full from empty.
module key_event_fifo #(
    parameter int unsigned W     = 19,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [W-1:0]             wr_data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;
    logic         do_push;
    logic         do_pop;

    assign count_o   = wr_ptr_q - rd_ptr_q;
    assign full_o    = (count_o == (AW+1)'(DEPTH));
    assign empty_o   = (count_o == '0);
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/key_event_encoder.sv
// Turns debounced key levels into timestamped press/release events queued toward the judge.
module key_event_encoder
    import key_event_encoder_pkg::*;
#(
    parameter int unsigned N_KEYS     = N_KEYS_DEF,
    parameter int unsigned KEY_W      = KEY_W_DEF,
    parameter int unsigned TS_W       = TS_W_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_KEYS-1:0]             key_lvl,
    input  logic                          tick,
    input  logic                          ts_clr,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [KEY_W-1:0]              ev_key,
    output logic                          ev_press,
    output logic [TS_W-1:0]               ev_ts,
    output logic [$clog2(FIFO_DEPTH):0]   ev_count,
    output logic                          ovf
);

    localparam int unsigned EW = KEY_W + 1 + TS_W;

    logic [TS_W-1:0]   ts_q, ts_d;
    logic [N_KEYS-1:0] prev_q;
    logic [N_KEYS-1:0] pend_vld_q, pend_vld_d;
    logic [N_KEYS-1:0] pend_press_q, pend_press_d;
    logic [TS_W-1:0]   pend_ts_q [N_KEYS];
    logic [TS_W-1:0]   pend_ts_d [N_KEYS];
    logic              ovf_q, ovf_d;

    logic [N_KEYS-1:0] edges;
    logic              found;
    logic [KEY_W-1:0]  sel;
    logic              sel_press;
    logic [TS_W-1:0]   sel_ts;
    logic              push;
    logic              pop;
    logic [EW-1:0]     head;
    logic              fifo_full;
    logic              fifo_empty;

    assign edges = key_lvl ^ prev_q;
    assign pop   = !fifo_empty && ev_ready;

    always_comb begin
        found     = 1'b0;
        sel       = '0;
        sel_press = 1'b0;
        sel_ts    = '0;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            if (!found && pend_vld_q[i]) begin
                found     = 1'b1;
                sel       = KEY_W'(i);
                sel_press = pend_press_q[i];
                sel_ts    = pend_ts_q[i];
            end
        end
        push = found && (!fifo_full || pop);
    end

    // A slot drained this cycle can take a new edge without it counting as a collision.
    always_comb begin
        pend_vld_d   = pend_vld_q;
        pend_press_d = pend_press_q;
        pend_ts_d    = pend_ts_q;
        ovf_d        = ovf_q;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            if (edges[i]) begin
                if (pend_vld_q[i] && !(push && sel == KEY_W'(i))) ovf_d = 1'b1;
                pend_vld_d[i]   = 1'b1;
                pend_press_d[i] = key_lvl[i];
                pend_ts_d[i]    = ts_q;
            end else if (push && sel == KEY_W'(i)) begin
                pend_vld_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        ts_d = ts_q;
        if (ts_clr)    ts_d = '0;
        else if (tick) ts_d = ts_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        prev_q <= key_lvl;
        if (rst) begin
            ts_q         <= '0;
            pend_vld_q   <= '0;
            pend_press_q <= '0;
            ovf_q        <= 1'b0;
            for (int unsigned i = 0; i < N_KEYS; i++) pend_ts_q[i] <= '0;
        end else begin
            ts_q         <= ts_d;
            pend_vld_q   <= pend_vld_d;
            pend_press_q <= pend_press_d;
            pend_ts_q    <= pend_ts_d;
            ovf_q        <= ovf_d;
        end
    end

    key_event_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (push),
        .wr_data_i ({sel, sel_press, sel_ts}),
        .pop_i     (pop),
        .rd_data_o (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (ev_count)
    );

    assign ev_valid = !fifo_empty;
    assign ev_key   = ev_valid ? head[EW-1 -: KEY_W] : '0;
    assign ev_press = ev_valid ? head[TS_W]          : 1'b0;
    assign ev_ts    = ev_valid ? head[TS_W-1:0]      : '0;
    assign ovf      = ovf_q;

endmodule
